// File: rtl/odd_parity_checker_pkg.sv
// ============================================================================
// Package : odd_parity_checker_pkg
// Shared definitions for the odd-parity link receiver: FSM state codes,
// default data width and an index-width helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package odd_parity_checker_pkg;

  // Default number of data bits per frame (parity bit not included)
  localparam int DEF_DATA_W = 3;

  // Receiver FSM state codes
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  // Width of a bit index into a DATA_W-wide word (never below 1)
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/odd_parity_checker_shift_reg.sv
// ============================================================================
// Module  : parity_shift_reg
// DATA_W-bit deserialising register with a running XOR accumulator.
// load  : starts a new word with the incoming bit at index 0.
// shift : writes the incoming bit at index idx and folds it into the parity.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_shift_reg
  import odd_parity_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = idx_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [IDX_W-1:0]  idx,
  input  logic              sin,
  output logic [DATA_W-1:0] word,
  output logic              parity
);

  // Capture serial bits into their final positions and track their XOR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word   <= '0;
      parity <= 1'b0;
    end else if (load) begin
      word   <= DATA_W'(sin);
      parity <= sin;
    end else if (shift) begin
      word[idx] <= sin;
      parity    <= parity ^ sin;
    end
  end

endmodule

`default_nettype wire

// File: rtl/odd_parity_checker.sv
// ============================================================================
// Module  : odd_parity_checker
// Receive side of the odd-parity link. Deserialises DATA_W data bits (LSB
// first) plus one odd-parity bit, then presents the word and a parity-error
// flag with a one-cycle out_valid pulse.
// Optional feature macro: ODD_PARITY_ERR_COUNT_EN (saturating error counter;
// when undefined err_cnt is tied to zero).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module odd_parity_checker
  import odd_parity_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic              in_bit,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int               IDX_W     = idx_width(DATA_W);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic [DATA_W-1:0]  word;
  logic               run_parity;
  logic               frame_start;
  logic               data_accept;
  logic               par_accept;
  logic               frame_err;

  // A start-qualified bit always opens a new frame, discarding any partial one
  assign frame_start = in_valid & in_start;
  assign data_accept = in_valid & ~in_start & (state == ST_DATA);
  assign par_accept  = in_valid & ~in_start & (state == ST_PAR);
  // Odd parity: total ones over data+parity must be odd
  assign frame_err   = ~(run_parity ^ in_bit);
  assign busy        = (state != ST_IDLE);

  parity_shift_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_shift_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (frame_start),
    .shift  (data_accept),
    .idx    (cnt),
    .sin    (in_bit),
    .word   (word),
    .parity (run_parity)
  );

  // Frame sequencing, bit counter and registered result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (frame_start) begin
        state <= (DATA_W == 1) ? ST_PAR : ST_DATA;
        cnt   <= FIRST_IDX;
      end else if (data_accept) begin
        cnt <= cnt + IDX_W'(1);
        if (cnt == LAST_IDX) begin
          state <= ST_PAR;
        end
      end else if (par_accept) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        out_valid  <= 1'b1;
        data_out   <= word;
        parity_err <= frame_err;
      end
    end
  end

`ifdef ODD_PARITY_ERR_COUNT_EN
  // Count frames with a parity violation, holding at the maximum value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (par_accept && frame_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

`default_nettype wire
